// File: rtl/latch_sync_capture_pkg.sv
`default_nettype none
// ============================================================================
// Module   : latch_sync_capture_pkg
// Brief    : Shared FSM encoding, counter widths and helpers for latch_sync_capture.
// Revision : 1.0 - initial release
// ============================================================================
package latch_sync_capture_pkg;

    localparam int c_glitch_w = 8;
    localparam int c_cnt_w    = 8;

    typedef enum logic [0:0] {
        STABLE = 1'b0,
        SETTLE = 1'b1
    } state_t;

    // Saturating increment: holds at all-ones instead of wrapping to zero.
    function automatic logic [c_glitch_w-1:0] sat_inc(input logic [c_glitch_w-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/latch_sync_capture_sync_ff_chain.sv
`default_nettype none
// ============================================================================
// Module   : sync_ff_chain
// Brief    : Per-bit multi-flop synchronizer with asynchronous active-low reset.
// Revision : 1.0 - initial release
// ============================================================================
module sync_ff_chain #(
    parameter int               WIDTH  = 1,
    parameter int               STAGES = 2,
    parameter logic [WIDTH-1:0] INIT   = '0
) (
    input  logic             CLK,
    input  logic             RESETN,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q
);

    logic [WIDTH-1:0] r_stage [STAGES];

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            for (int i = 0; i < STAGES; i++) begin
                r_stage[i] <= INIT;
            end
        end else begin
            r_stage[0] <= D;
            for (int i = 1; i < STAGES; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign Q = r_stage[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/latch_sync_capture.sv
`default_nettype none
// ============================================================================
// Module   : latch_sync_capture
// Brief    : Synchronizes and debounces latch outputs; Q updates only after
//            SYNC has held a new value for STABLE_CNT cycles.
//            Define LATCH_SYNC_GLITCH_CNT_EN to build the GLITCHES counter.
// Revision : 1.0 - initial release
// ============================================================================
module latch_sync_capture
    import latch_sync_capture_pkg::*;
#(
    parameter int               WIDTH       = 1,
    parameter int               SYNC_STAGES = 2,
    parameter int               STABLE_CNT  = 3,
    parameter logic [WIDTH-1:0] INIT        = '0
) (
    input  logic                  CLK,
    input  logic                  RESETN,
    input  logic [WIDTH-1:0]      D,
    output logic [WIDTH-1:0]      Q,
    output logic                  CHG,
    output logic                  BUSY,
    output logic [c_glitch_w-1:0] GLITCHES
);

    if (WIDTH < 1 || WIDTH > 32) begin : g_chk_width
        $fatal(1, "latch_sync_capture: WIDTH=%0d outside 1..32", WIDTH);
    end
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_chk_stages
        $fatal(1, "latch_sync_capture: SYNC_STAGES=%0d outside 2..4", SYNC_STAGES);
    end
    if (STABLE_CNT < 1 || STABLE_CNT > 255) begin : g_chk_cnt
        $fatal(1, "latch_sync_capture: STABLE_CNT=%0d outside 1..255", STABLE_CNT);
    end

    localparam logic [c_cnt_w-1:0] c_cnt_load = c_cnt_w'(STABLE_CNT);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(1);

    logic [WIDTH-1:0]   w_sync;
    logic [WIDTH-1:0]   r_sync_prev;
    logic [WIDTH-1:0]   r_q;
    logic               r_chg;
    state_t             r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic               w_change;
    logic               w_differs;

    sync_ff_chain #(
        .WIDTH  (WIDTH),
        .STAGES (SYNC_STAGES),
        .INIT   (INIT)
    ) u_sync (
        .CLK    (CLK),
        .RESETN (RESETN),
        .D      (D),
        .Q      (w_sync)
    );

    assign w_change  = (w_sync != r_sync_prev);
    assign w_differs = (w_sync != r_q);

    // Any movement of SYNC restarts the settle window; a settle only completes
    // after a full quiet window with SYNC still different from Q.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_state     <= STABLE;
            r_cnt       <= '0;
            r_q         <= INIT;
            r_chg       <= 1'b0;
            r_sync_prev <= INIT;
        end else begin
            r_sync_prev <= w_sync;
            r_chg       <= 1'b0;
            case (r_state)
                STABLE: begin
                    if (w_change && w_differs) begin
                        r_state <= SETTLE;
                        r_cnt   <= c_cnt_load;
                    end
                end
                SETTLE: begin
                    if (w_change) begin
                        if (w_differs) begin
                            r_cnt <= c_cnt_load;
                        end else begin
                            r_state <= STABLE;
                        end
                    end else begin
                        if (r_cnt != '0) begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                        if (r_cnt == c_cnt_last) begin
                            r_q     <= w_sync;
                            r_chg   <= 1'b1;
                            r_state <= STABLE;
                        end
                    end
                end
                default: r_state <= STABLE;
            endcase
        end
    end

    assign Q    = r_q;
    assign CHG  = r_chg;
    assign BUSY = (r_state == SETTLE);

`ifdef LATCH_SYNC_GLITCH_CNT_EN
    logic                  w_glitch;
    logic [c_glitch_w-1:0] r_glitches;

    // Every SYNC movement during a settle aborts that settle window.
    assign w_glitch = (r_state == SETTLE) && w_change;

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_glitches <= '0;
        end else if (w_glitch) begin
            r_glitches <= sat_inc(r_glitches);
        end
    end

    assign GLITCHES = r_glitches;
`else
    assign GLITCHES = '0;
`endif

endmodule
`default_nettype wire

// File: doc/latch_sync_capture.md
LATCH_SYNC_CAPTURE -- requirements
Module: latch_sync_capture

Interface
REQ-001 Parameter WIDTH, default 1: data width, legal range 1..32.
REQ-002 Parameter SYNC_STAGES, default 2: synchronizer depth, legal range 2..4.
REQ-003 Parameter STABLE_CNT, default 3: debounce cycles, legal range 1..255.
REQ-004 Parameter INIT, default all zeros: WIDTH-bit reset and initial value of all data state.
REQ-005 Port CLK, input, 1 bit: single clock; all flops rising-edge.
REQ-006 Port RESETN, input, 1 bit: asynchronous, active-low reset.
REQ-007 Port D, input, WIDTH bits: asynchronous data, typically the Q outputs of upstream latches.
REQ-008 Port Q, output, WIDTH bits: synchronized, debounced data.
REQ-009 Port CHG, output, 1 bit: one-cycle pulse when Q updates.
REQ-010 Port BUSY, output, 1 bit: high while a settle is in progress.
REQ-011 Port GLITCHES, output, 8 bits: count of aborted settles.

Function
REQ-012 D SHALL pass through a SYNC_STAGES-deep flop chain per bit; the last stage is SYNC.
REQ-013 A register SYNC_PREV SHALL hold SYNC delayed by one cycle; a change is SYNC != SYNC_PREV.
REQ-014 The FSM SHALL have two states: STABLE (BUSY=0) and SETTLE (BUSY=1).
REQ-015 STABLE with a change and SYNC != Q: go to SETTLE and load CNT with STABLE_CNT.
REQ-016 SETTLE with no change: CNT decrements by one.
REQ-017 SETTLE with no change and CNT==1: Q <= SYNC, CHG=1 for exactly one cycle, go to STABLE.
REQ-018 SETTLE with a change and SYNC != Q: reload CNT with STABLE_CNT, stay in SETTLE, increment GLITCHES.
REQ-019 SETTLE with a change and SYNC == Q: go to STABLE, no CHG, increment GLITCHES.
REQ-020 Latency: a clean D change set up before edge k SHALL update Q and assert CHG at edge k+SYNC_STAGES+STABLE_CNT.
REQ-021 CNT SHALL be 8 bits; it SHALL never underflow and never be decremented in STABLE.
REQ-022 GLITCHES SHALL saturate at 255 and never wrap.
REQ-023 CHG SHALL be registered; Q and CHG SHALL change on the same edge.

Reset
REQ-024 RESETN low SHALL asynchronously force: sync chain, SYNC_PREV and Q = INIT; CNT = 0; GLITCHES = 0; CHG = 0; state STABLE.
REQ-025 Reset asserted mid-settle SHALL abandon the settle without a CHG pulse or a GLITCHES increment.
REQ-026 Reset deassertion SHALL take effect at the next rising CLK edge; there SHALL be no internal reset synchronizer.

Configuration
REQ-027 Macro LATCH_SYNC_GLITCH_CNT_EN defined: the GLITCHES counter SHALL be implemented as specified above.
REQ-028 Macro undefined: GLITCHES SHALL be tied to 0, no counter flops SHALL exist, and all other behaviour SHALL be unchanged.

Structure
REQ-029 A shared package SHALL hold: the FSM state encoding (STABLE=0, SETTLE=1), the GLITCHES width constant (8), and the CNT width constant (8).
REQ-030 The synchronizer SHALL be a sub-module sync_ff_chain (parameters WIDTH, STAGES, INIT; ports CLK, RESETN, D, Q), instantiated once.
REQ-031 Parameter legality SHALL be checked at elaboration; an out-of-range value is a fatal error.

Verification
Default setup for all scenarios: WIDTH=4, SYNC_STAGES=2, STABLE_CNT=3, INIT=4'h0.
REQ-032 Clean change: D 0->A set up before edge 10 -> Q=A with a single CHG pulse at edge 15; BUSY high edges 12..14.
REQ-033 Glitch return: D 0->5 at edge 10, back to 0 at edge 11 -> no CHG, Q stays 0, GLITCHES=1, BUSY low again by edge 14.
REQ-034 Re-change: D 0->3 at edge 10, 3->7 at edge 12 -> one CHG at edge 17 with Q=7; GLITCHES=1.
REQ-035 Saturation: 300 alternating glitches -> GLITCHES holds at 255; with the macro undefined, GLITCHES stays 0 throughout.
REQ-036 Reset: RESETN pulsed low mid-SETTLE (edge 13 of REQ-032) -> immediately Q=0, BUSY=0, CHG=0; no CHG follows while D is held at 0.
REQ-037 Depth variant: SYNC_STAGES=4, STABLE_CNT=1, D change before edge 20 -> CHG and Q update at edge 25.
